jop_alarm_mc: RTL and testbench

- Multi-channel successor of the single-counter JOP detector; one independent detector per hart or execution stream.
- Each channel runs a saturating up/down counter driven by the retired-instruction stream: up-step on an indirect jump, down-step on any other valid instruction.
- Per-channel hysteresis alarm FSM with optional sticky mode, edge-pulse output for the interrupt controller, and a global synchronous clear.
- Sits between core trace outputs and the security alarm aggregator.

---
 rtl/jop_alarm_mc.sv | 116 +++++++++++
 tb/tb_jop_alarm_mc.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jop_alarm_mc.sv
// Multi-channel JOP detector: per-channel saturating up/down counter on the
// retired-instruction stream, with a hysteresis (optionally sticky) alarm FSM.
//   state    | meaning
//   ST_IDLE  | counter has not crossed the high threshold, no alarm
//   ST_ALARM | alarm raised; leaves below the low threshold unless sticky
module jop_alarm_mc #(
  parameter int NumChannels   = 1,
  parameter int CntWidth      = 16,
  parameter int StepUpValue   = 10,
  parameter int StepDownValue = 20,
  parameter int ThresholdHi   = 100,
  parameter int ThresholdLo   = 50,
  parameter int Sticky        = 0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [NumChannels-1:0]          instr_valid_i,
  input  logic [NumChannels-1:0]          is_ind_jump_i,
  input  logic                            clear_i,
  output logic [NumChannels*CntWidth-1:0] cnt_o,
  output logic [NumChannels-1:0]          alarm_o,
  output logic [NumChannels-1:0]          alarm_pulse_o,
  output logic                            alarm_any_o
);

  localparam longint MaxVal = (longint'(1) << CntWidth) - 1;

  if (ThresholdLo > ThresholdHi) begin : g_chk_thr_order
    $fatal(1, "ThresholdLo must not exceed ThresholdHi");
  end
  if (longint'(ThresholdHi) >= MaxVal) begin : g_chk_thr_hi
    $fatal(1, "ThresholdHi must be below the counter maximum");
  end
  if (StepUpValue <= 0 || longint'(StepUpValue) > MaxVal) begin : g_chk_up
    $fatal(1, "StepUpValue out of range");
  end
  if (StepDownValue <= 0 || longint'(StepDownValue) > MaxVal) begin : g_chk_dn
    $fatal(1, "StepDownValue out of range");
  end
  if (NumChannels < 1) begin : g_chk_nch
    $fatal(1, "NumChannels must be at least 1");
  end

  typedef enum logic {ST_IDLE, ST_ALARM} state_e;

  localparam logic [CntWidth:0]   MaxCnt     = {1'b0, {CntWidth{1'b1}}};
  localparam logic [CntWidth:0]   UpStep     = (CntWidth+1)'(StepUpValue);
  localparam logic [CntWidth:0]   DnStep     = (CntWidth+1)'(StepDownValue);
  localparam logic [CntWidth-1:0] ThrHi      = CntWidth'(ThresholdHi);
  localparam logic [CntWidth-1:0] ThrLo      = CntWidth'(ThresholdLo);
  localparam bit                  StickyMode = (Sticky != 0);

  logic [CntWidth-1:0]    cnt_q   [NumChannels];
  logic [CntWidth-1:0]    cnt_d   [NumChannels];
  state_e                 state_q [NumChannels];
  state_e                 state_d [NumChannels];
  logic [NumChannels-1:0] pulse_q;
  logic [NumChannels-1:0] pulse_d;
  logic [CntWidth:0]      arith_w;

  always_comb begin
    arith_w = '0;
    pulse_d = '0;
    for (int c = 0; c < NumChannels; c++) begin
      cnt_d[c]   = cnt_q[c];
      state_d[c] = state_q[c];
      // One extra bit of headroom so saturation and floor are detected, never wrapped.
      if (instr_valid_i[c]) begin
        if (is_ind_jump_i[c]) begin
          arith_w  = {1'b0, cnt_q[c]} + UpStep;
          cnt_d[c] = (arith_w > MaxCnt) ? MaxCnt[CntWidth-1:0] : arith_w[CntWidth-1:0];
        end else if ({1'b0, cnt_q[c]} < DnStep) begin
          cnt_d[c] = '0;
        end else begin
          arith_w  = {1'b0, cnt_q[c]} - DnStep;
          cnt_d[c] = arith_w[CntWidth-1:0];
        end
      end
      case (state_q[c])
        ST_IDLE:  if (cnt_d[c] > ThrHi) state_d[c] = ST_ALARM;
        ST_ALARM: if (!StickyMode && (cnt_d[c] < ThrLo)) state_d[c] = ST_IDLE;
        default:  state_d[c] = ST_IDLE;
      endcase
      if (clear_i) begin
        cnt_d[c]   = '0;
        state_d[c] = ST_IDLE;
      end
      pulse_d[c] = (state_q[c] == ST_IDLE) && (state_d[c] == ST_ALARM);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int c = 0; c < NumChannels; c++) begin
        cnt_q[c]   <= '0;
        state_q[c] <= ST_IDLE;
      end
      pulse_q <= '0;
    end else begin
      for (int c = 0; c < NumChannels; c++) begin
        cnt_q[c]   <= cnt_d[c];
        state_q[c] <= state_d[c];
      end
      pulse_q <= pulse_d;
    end
  end

  for (genvar c = 0; c < NumChannels; c++) begin : g_out
    assign cnt_o[c*CntWidth +: CntWidth] = cnt_q[c];
    assign alarm_o[c]                    = (state_q[c] == ST_ALARM);
  end

  assign alarm_pulse_o = pulse_q;
  assign alarm_any_o   = |alarm_o;

endmodule

// File: tb/tb_jop_alarm_mc.sv
// Bench for jop_alarm_mc: three instances (4-channel default, 8-bit counter,
// sticky) checked every cycle against a reference model via a scoreboard queue.
module tb_jop_alarm_mc;

  localparam int Hi = 100;
  localparam int Lo = 50;
  localparam int Up = 10;
  localparam int Dn = 20;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [3:0]  va = '0, ja = '0;
  logic        clr_a = 1'b0;
  logic        vb = 1'b0, jb = 1'b0, clr_b = 1'b0;
  logic        vc = 1'b0, jc = 1'b0, clr_c = 1'b0;
  logic [63:0] cnt_a;
  logic [3:0]  alarm_a, pulse_a;
  logic        any_a;
  logic [7:0]  cnt_b;
  logic        alarm_b, pulse_b, any_b;
  logic [15:0] cnt_c;
  logic        alarm_c, pulse_c, any_c;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int idx;
    int cnt;
    bit alm;
    bit pulse;
  } exp_t;

  exp_t sb_q[$];
  int   m_cnt[6];
  bit   m_alm[6];

  always #5 clk_i = ~clk_i;

  jop_alarm_mc #(.NumChannels(4)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_valid_i(va), .is_ind_jump_i(ja),
    .clear_i(clr_a), .cnt_o(cnt_a), .alarm_o(alarm_a), .alarm_pulse_o(pulse_a),
    .alarm_any_o(any_a));

  jop_alarm_mc #(.NumChannels(1), .CntWidth(8)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_valid_i(vb), .is_ind_jump_i(jb),
    .clear_i(clr_b), .cnt_o(cnt_b), .alarm_o(alarm_b), .alarm_pulse_o(pulse_b),
    .alarm_any_o(any_b));

  jop_alarm_mc #(.NumChannels(1), .Sticky(1)) u_dut_c (
    .clk_i(clk_i), .rst_ni(rst_ni), .instr_valid_i(vc), .is_ind_jump_i(jc),
    .clear_i(clr_c), .cnt_o(cnt_c), .alarm_o(alarm_c), .alarm_pulse_o(pulse_c),
    .alarm_any_o(any_c));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_step(input int cnt, input bit alm, input bit v, input bit j,
                                     input bit clr, input int maxc, input bit sticky,
                                     output int ncnt, output bit nalm, output bit npulse);
    ncnt = cnt;
    if (v && j) ncnt = (cnt + Up > maxc) ? maxc : cnt + Up;
    else if (v) ncnt = (cnt < Dn) ? 0 : cnt - Dn;
    if (!alm) nalm = (ncnt > Hi);
    else if (sticky) nalm = 1'b1;
    else nalm = !(ncnt < Lo);
    if (clr) begin
      ncnt = 0;
      nalm = 1'b0;
    end
    npulse = nalm && !alm;
  endfunction

  function automatic int get_cnt(input int i);
    if (i < 4) return int'(cnt_a[i*16 +: 16]);
    if (i == 4) return int'(cnt_b);
    return int'(cnt_c);
  endfunction

  function automatic bit get_alm(input int i);
    if (i < 4) return alarm_a[i];
    if (i == 4) return alarm_b;
    return alarm_c;
  endfunction

  function automatic bit get_pulse(input int i);
    if (i < 4) return pulse_a[i];
    if (i == 4) return pulse_b;
    return pulse_c;
  endfunction

  task automatic idle_all();
    va = '0; ja = '0; clr_a = 1'b0;
    vb = 1'b0; jb = 1'b0; clr_b = 1'b0;
    vc = 1'b0; jc = 1'b0; clr_c = 1'b0;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 6; i++) begin
      m_cnt[i] = 0;
      m_alm[i] = 1'b0;
    end
  endtask

  // Predict the next edge for every channel, clock it, then compare.
  task automatic cycle();
    bit v, j, c, st, na, np;
    int mx, nc;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin v = va[i]; j = ja[i]; c = clr_a; mx = 65535; st = 1'b0; end
      else if (i == 4) begin v = vb; j = jb; c = clr_b; mx = 255; st = 1'b0; end
      else begin v = vc; j = jc; c = clr_c; mx = 65535; st = 1'b1; end
      model_step(m_cnt[i], m_alm[i], v, j, c, mx, st, nc, na, np);
      m_cnt[i] = nc;
      m_alm[i] = na;
      sb_q.push_back('{i, nc, na, np});
    end
    @(posedge clk_i);
    #1;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check($sformatf("cnt[%0d]", e.idx), get_cnt(e.idx), e.cnt);
      check($sformatf("alarm[%0d]", e.idx), get_alm(e.idx), e.alm);
      check($sformatf("pulse[%0d]", e.idx), get_pulse(e.idx), e.pulse);
    end
    check("any_a", any_a, m_alm[0] | m_alm[1] | m_alm[2] | m_alm[3]);
    check("any_b", any_b, m_alm[4]);
    check("any_c", any_c, m_alm[5]);
  endtask

  initial begin
    idle_all();
    reset_model();
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_cnt_a", cnt_a, 0);
    check("rst_alarm_a", alarm_a, 0);
    check("rst_any_a", any_a, 0);
    check("rst_pulse_a", pulse_a, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Channel 0 rise to alarm, then hysteresis fall with idle gaps
    va = 4'b0001; ja = 4'b0001;
    repeat (10) cycle();
    check("p1_cnt100", cnt_a[15:0], 100);
    check("p1_noalarm", alarm_a[0], 0);
    cycle();
    check("p1_cnt110", cnt_a[15:0], 110);
    check("p1_alarm", alarm_a[0], 1);
    check("p1_pulse", pulse_a[0], 1);
    va = '0; ja = '0;
    cycle();
    check("p1_pulse_drop", pulse_a[0], 0);
    check("p1_alarm_hold", alarm_a[0], 1);
    for (int k = 0; k < 4; k++) begin
      va = 4'b0001; ja = 4'b0000;
      cycle();
      check($sformatf("p1_dec%0d", k), cnt_a[15:0], 90 - 20 * k);
      check($sformatf("p1_alm%0d", k), alarm_a[0], (k < 3) ? 1 : 0);
      va = '0;
      cycle();
      check($sformatf("p1_hold%0d", k), cnt_a[15:0], 90 - 20 * k);
    end

    // 8-bit counter saturation and floor
    idle_all();
    vb = 1'b1; jb = 1'b1;
    repeat (30) cycle();
    check("p2_sat", cnt_b, 255);
    cycle();
    check("p2_sat_hold", cnt_b, 255);
    clr_b = 1'b1;
    cycle();
    check("p2_clear", cnt_b, 0);
    clr_b = 1'b0;
    cycle();
    check("p2_cnt10", cnt_b, 10);
    jb = 1'b0;
    cycle();
    check("p2_floor", cnt_b, 0);

    // Sticky alarm survives a drained counter until cleared
    idle_all();
    vc = 1'b1; jc = 1'b1;
    repeat (11) cycle();
    check("p3_alarm", alarm_c, 1);
    jc = 1'b0;
    repeat (20) cycle();
    check("p3_cnt0", cnt_c, 0);
    check("p3_sticky", alarm_c, 1);
    jc = 1'b1; clr_c = 1'b1;
    cycle();
    check("p3_clr_cnt", cnt_c, 0);
    check("p3_clr_alarm", alarm_c, 0);
    check("p3_clr_pulse", pulse_c, 0);

    // Channel independence on the 4-channel instance
    idle_all();
    va = 4'b0100; ja = 4'b0100;
    repeat (11) cycle();
    check("p4_alarm_vec", alarm_a, 4'b0100);
    check("p4_any", any_a, 1);
    check("p4_cnt1", cnt_a[31:16], 0);
    check("p4_cnt3", cnt_a[63:48], 0);
    va = 4'b0101; ja = 4'b0001;
    cycle();
    check("p4_ch0_inc", cnt_a[15:0], 40);
    check("p4_ch2_dec", cnt_a[47:32], 90);
    check("p4_ch2_alarm", alarm_a[2], 1);

    // Asynchronous reset in mid-cycle while an alarm is up
    idle_all();
    #3;
    rst_ni = 1'b0;
    #1;
    check("p5_async_cnt", cnt_a, 0);
    check("p5_async_alarm", alarm_a, 0);
    check("p5_async_any", any_a, 0);
    reset_model();
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    va = 4'b0100; ja = 4'b0100;
    cycle();
    check("p5_restart", cnt_a[47:32], 10);

    // Randomised traffic with occasional clears
    for (int n = 0; n < 300; n++) begin
      for (int c = 0; c < 4; c++) begin
        va[c] = ($urandom_range(0, 3) != 0);
        ja[c] = ($urandom_range(0, 3) != 0);
      end
      clr_a = ($urandom_range(0, 40) == 0);
      vb = ($urandom_range(0, 3) != 0);
      jb = ($urandom_range(0, 3) != 0);
      clr_b = ($urandom_range(0, 40) == 0);
      vc = ($urandom_range(0, 3) != 0);
      jc = ($urandom_range(0, 2) != 0);
      clr_c = ($urandom_range(0, 40) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
